// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the five-stage pipeline sequencing controller:
// opcode constants, FSM states, forwarding selects and shadow metadata.
package pipeline_ctrl_pkg;

  localparam int unsigned RIDX_W = 5;

  localparam logic [6:0] RCC   = 7'b0110011;
  localparam logic [6:0] MCC   = 7'b0010011;
  localparam logic [6:0] LCC   = 7'b0000011;
  localparam logic [6:0] SCC   = 7'b0100011;
  localparam logic [6:0] BCC   = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    REDIR = 2'd2,
    MWAIT = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] rd;
    logic              we;
    logic              is_load;
  } shadow_t;

  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, LCC, MCC, RCC};
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {JALR, BCC, LCC, SCC, MCC, RCC};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {BCC, SCC, RCC};
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational hazard detection and operand-forwarding select.
// PIPELINE_FWD_EN selects forwarding + load-use; otherwise full interlock.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REGW = RIDX_W
) (
  input  logic            uses_rs1_d,
  input  logic            uses_rs2_d,
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  input  logic [REGW-1:0] rs1_x,
  input  logic [REGW-1:0] rs2_x,
  input  shadow_t         sh_x,
  input  shadow_t         sh_m,
  input  shadow_t         sh_w,
  output logic            ld_hit,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel
);

  // we is only ever set for rd != 0, so x0 can never match here
  function automatic logic writer_is(input shadow_t s, input logic [REGW-1:0] rs);
    return s.valid && s.we && (s.rd == rs);
  endfunction

  function automatic logic d_reads(input shadow_t s, input logic u1, input logic u2,
                                   input logic [REGW-1:0] r1, input logic [REGW-1:0] r2);
    return (u1 && writer_is(s, r1)) || (u2 && writer_is(s, r2));
  endfunction

`ifdef PIPELINE_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] rs,
                                         input shadow_t m, input shadow_t w);
    if (rs == '0)                         return FWD_RF;
    if (writer_is(m, rs) && !m.is_load)   return FWD_M;
    if (writer_is(w, rs))                 return FWD_W;
    return FWD_RF;
  endfunction

  logic unused_w_ld;

  assign ld_hit      = sh_x.is_load && d_reads(sh_x, uses_rs1_d, uses_rs2_d, rs1_d, rs2_d);
  assign fwd_a_sel   = fwd_sel(rs1_x, sh_m, sh_w);
  assign fwd_b_sel   = fwd_sel(rs2_x, sh_m, sh_w);
  assign unused_w_ld = sh_w.is_load;
`else
  logic unused_fwd;

  assign ld_hit = d_reads(sh_x, uses_rs1_d, uses_rs2_d, rs1_d, rs2_d)
               || d_reads(sh_m, uses_rs1_d, uses_rs2_d, rs1_d, rs2_d)
               || d_reads(sh_w, uses_rs1_d, uses_rs2_d, rs1_d, rs2_d);
  assign fwd_a_sel  = FWD_RF;
  assign fwd_b_sel  = FWD_RF;
  assign unused_fwd = ^{rs1_x, rs2_x, sh_x.is_load, sh_m.is_load, sh_w.is_load};
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencing controller: FSM, X/M/W shadow metadata,
// stall/flush/valid generation. Optional feature macro: PIPELINE_FWD_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = RIDX_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst_d,
  input  logic [XLEN-1:0] inst_x,
  input  logic            PCSel,
  input  logic            dmem_wait,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_x,
  output logic            stall_m,
  output logic            valid_x,
  output logic            valid_m,
  output logic            valid_w,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel
);

  state_e          state_q, state_d;
  shadow_t         x_q, m_q, w_q, x_d, m_d, w_d;
  logic [6:0]      op_d;
  logic [REGW-1:0] rd_d, rs1_d, rs2_d, rs1_x, rs2_x;
  logic            ld_hit;
  logic [1:0]      fwd_a_hd, fwd_b_hd;
  logic            unused_fields;

  assign op_d          = inst_d[6:0];
  assign rd_d          = inst_d[11:7];
  assign rs1_d         = inst_d[19:15];
  assign rs2_d         = inst_d[24:20];
  assign rs1_x         = inst_x[19:15];
  assign rs2_x         = inst_x[24:20];
  assign unused_fields = ^{inst_d[31:25], inst_d[14:12], inst_x[31:25], inst_x[14:0]};

  hazard_detect #(.REGW(REGW)) u_hazard (
    .uses_rs1_d (uses_rs1(op_d)),
    .uses_rs2_d (uses_rs2(op_d)),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rs1_x      (rs1_x),
    .rs2_x      (rs2_x),
    .sh_x       (x_q),
    .sh_m       (m_q),
    .sh_w       (w_q),
    .ld_hit     (ld_hit),
    .fwd_a_sel  (fwd_a_hd),
    .fwd_b_sel  (fwd_b_hd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      x_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_q     <= m_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    state_d = RUN;
    if (dmem_wait)               state_d = MWAIT;
    else if (PCSel && x_q.valid) state_d = REDIR;
    else if (ld_hit)             state_d = LDUSE;
  end

  // The cycle after a redirect, F/D holds the flushed NOP, so what moves
  // into X then is the second squashed slot and is not marked valid.
  always_comb begin
    x_d = x_q;
    m_d = m_q;
    w_d = w_q;
    if (state_d != MWAIT) begin
      w_d         = m_q;
      m_d         = x_q;
      x_d.valid   = !(state_d inside {REDIR, LDUSE}) && (state_q != REDIR);
      x_d.rd      = rd_d;
      x_d.we      = writes_rd(op_d) && (rd_d != '0);
      x_d.is_load = (op_d == LCC);
      if (!x_d.valid) x_d = '0;
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_x = 1'b0;
    stall_m = 1'b0;
    if (rst_n) begin
      case (state_d)
        MWAIT: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_m = 1'b1;
        end
        REDIR: begin
          flush_d = 1'b1;
          flush_x = 1'b1;
        end
        LDUSE: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_x = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign valid_x   = x_q.valid;
  assign valid_m   = m_q.valid;
  assign valid_w   = w_q.valid;
  assign fwd_a_sel = rst_n ? fwd_a_hd : FWD_RF;
  assign fwd_b_sel = rst_n ? fwd_b_hd : FWD_RF;

endmodule
